// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Program entry points live here so top-level builds can re-point them.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] PROG_SEL_P1      = 2'd0;
    localparam logic [1:0] PROG_SEL_P2      = 2'd1;
    localparam logic [1:0] PROG_SEL_P3      = 2'd2;
    localparam logic [1:0] PROG_SEL_INVALID = 2'd3;

    localparam int DEF_PROG1_START = 0;
    localparam int DEF_PROG2_START = 1024;
    localparam int DEF_PROG3_START = 2048;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter sequencer for a 2**IMEM_AW-entry instruction memory:
// program select, stall/halt/branch handling and benchmark counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int IMEM_AW     = 12,
    parameter int PROG1_START = DEF_PROG1_START,
    parameter int PROG2_START = DEF_PROG2_START,
    parameter int PROG3_START = DEF_PROG3_START,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           prog_sel,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 halt,
    output logic [PC_WIDTH-1:0]  current_pc,
    output logic                 fetch_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_t             state, state_nxt;
    logic [IMEM_AW-1:0] pc, pc_nxt;
    logic               cnt_clear, cyc_inc, ins_inc;

    // Target bits above the imem address range are intentionally discarded.
    logic unused_tgt_hi;
    assign unused_tgt_hi = ^branch_target[PC_WIDTH-1:IMEM_AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_clear = 1'b0;
        cyc_inc   = 1'b0;
        ins_inc   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && (prog_sel != PROG_SEL_INVALID)) begin
                    state_nxt = RUN;
                    cnt_clear = 1'b1;
                    case (prog_sel)
                        PROG_SEL_P1: pc_nxt = IMEM_AW'(PROG1_START);
                        PROG_SEL_P2: pc_nxt = IMEM_AW'(PROG2_START);
                        default:     pc_nxt = IMEM_AW'(PROG3_START);
                    endcase
                end
            end
            RUN: begin
                cyc_inc = 1'b1;
                // Stall masks halt and branch: the instruction is not consumed.
                if (stall) begin
                    pc_nxt = pc;
                end else if (halt) begin
                    ins_inc   = 1'b1;
                    state_nxt = DONE;
                end else if (branch_taken) begin
                    ins_inc = 1'b1;
                    pc_nxt  = branch_target[IMEM_AW-1:0];
                end else begin
                    ins_inc = 1'b1;
                    pc_nxt  = pc + IMEM_AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign current_pc  = {{(PC_WIDTH-IMEM_AW){1'b0}}, pc};
    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign fetch_valid = busy && !stall;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cyc_inc),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (ins_inc),
        .count (instr_count)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and random checks of fetch_sequencer against a behavioural model;
// a 4-bit-counter copy shares the stimulus to exercise saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  prog_sel = 2'd0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        halt = 1'b0;

    logic [31:0] current_pc, cycle_count, instr_count;
    logic        fetch_valid, busy, done;
    logic [31:0] s_pc;
    logic [3:0]  s_cyc, s_ins;
    logic        s_fv, s_busy, s_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain integers, no register-level structure.
    bit      m_run = 0, m_done = 0;
    longint  m_pc = 0, m_cyc = 0, m_ins = 0;
    longint  starts [3] = '{0, 1024, 2048};

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .current_pc(current_pc), .fetch_valid(fetch_valid),
        .busy(busy), .done(done), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    fetch_sequencer #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .current_pc(s_pc), .fetch_valid(s_fv),
        .busy(s_busy), .done(s_done), .cycle_count(s_cyc), .instr_count(s_ins)
    );

    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(string tag, longint obs, longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        longint fv_exp = (m_run && !stall) ? 1 : 0;
        check({tag, ".pc"},    longint'(current_pc), m_pc);
        check({tag, ".busy"},  longint'(busy), longint'(m_run));
        check({tag, ".done"},  longint'(done), longint'(m_done));
        check({tag, ".fv"},    longint'(fetch_valid), fv_exp);
        check({tag, ".cyc"},   longint'(cycle_count), sat(m_cyc, 32));
        check({tag, ".ins"},   longint'(instr_count), sat(m_ins, 32));
        check({tag, ".s_cyc"}, longint'(s_cyc), sat(m_cyc, 4));
        check({tag, ".s_ins"}, longint'(s_ins), sat(m_ins, 4));
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0;
    endtask

    // Apply the current inputs for one clock, advance the model, then check.
    task automatic step(string tag);
        if (!m_run) begin
            if (start && prog_sel != 2'd3) begin
                m_pc = starts[prog_sel]; m_cyc = 0; m_ins = 0;
                m_run = 1; m_done = 0;
            end
        end else begin
            m_cyc++;
            if (stall) begin
            end else if (halt) begin
                m_ins++; m_run = 0; m_done = 1;
            end else if (branch_taken) begin
                m_ins++; m_pc = branch_target % 4096;
            end else begin
                m_ins++; m_pc = (m_pc + 1) % 4096;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(bit st, logic [1:0] sel, bit stl, bit br, logic [31:0] tgt, bit hlt);
        start = st; prog_sel = sel; stall = stl; branch_taken = br;
        branch_target = tgt; halt = hlt;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        #1 reset = 1'b0;
    endtask

    initial begin
        #3;
        check_all("por");
        reset = 1'b0;

        // Build PC=37 with 20 counted cycles, then reset between edges.
        drive(1, 2'd0, 0, 0, 0, 0); step("start_p1");
        drive(0, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) step("free_run");
        drive(0, 2'd0, 0, 1, 32'd37, 0); step("br37");
        drive(0, 2'd0, 0, 0, 0, 0);
        do_reset();

        // Program 2 entry and 5 free fetches.
        drive(1, 2'd1, 0, 0, 0, 0); step("start_p2");
        drive(0, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("p2_free");
        check("p2_pc1029", longint'(current_pc), 1029);

        // Wrap at the top of imem and drop target upper bits.
        drive(0, 2'd0, 0, 1, 32'd4095, 0); step("br4095");
        drive(0, 2'd0, 0, 0, 0, 0); step("wrap");
        check("wrap_pc0", longint'(current_pc), 0);
        drive(0, 2'd0, 0, 1, 32'h0001_2005, 0); step("br_trunc");
        check("trunc_pc5", longint'(current_pc), 5);

        // Stall dominates halt and branch; start during RUN ignored.
        drive(1, 2'd2, 1, 1, 32'd99, 1); step("stall_all");
        drive(1, 2'd2, 0, 0, 0, 0); step("start_in_run");

        // Halt at PC=10 after 10 fetches, then invalid and valid restart.
        drive(0, 2'd0, 0, 0, 0, 0);
        do_reset();
        drive(1, 2'd0, 0, 0, 0, 0); step("start_p1b");
        drive(0, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("to10");
        drive(0, 2'd0, 0, 0, 0, 1); step("halt10");
        check("halt_ins11", longint'(instr_count), 11);
        drive(0, 2'd0, 0, 0, 0, 0); step("done_hold");
        drive(1, 2'd3, 0, 0, 0, 0); step("start_inv");
        drive(1, 2'd2, 0, 0, 0, 0); step("start_p3");
        check("p3_pc2048", longint'(current_pc), 2048);

        // Saturation of the 4-bit copy: 20 cycles with a mix of stalls.
        drive(0, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            stall = (i % 3 == 0);
            step("sat_run");
        end
        check("sat_cyc_f", longint'(s_cyc), 15);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                  $urandom(), ($urandom_range(0, 40) == 0));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
